// File: rtl/key_cmd_ctrl.sv
// rtl/key_cmd_ctrl.sv - button sync/debounce, press and long-press detect, run/pause FSM
// Bit 0 of every per-button vector is the start button, bit 1 is the dir button.
module key_cmd_ctrl #(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int LONG_CYCLES = 200_000_000,
  parameter int CNT_W       = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_dir,
  output logic       run,
  output logic       paused,
  output logic       dir,
  output logic       clear,
  output logic       start_pulse,
  output logic       dir_pulse,
  output logic [1:0] state
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_PRE  = CNT_W'(LONG_CYCLES - 2);

  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            db_q, db_d;
  logic [1:0]            db_dly_q, db_dly_d;
  logic [1:0]            pulse_q, pulse_d;
  logic [1:0][CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0]      hcnt_q, hcnt_d;
  logic [1:0]            state_q, state_d;
  logic                  dir_q, dir_d;
  logic                  clear_q, clear_d;
  logic                  run_q, run_d;
  logic                  paused_q, paused_d;
  logic                  long_hit;
  logic                  active;

  always_comb begin
    sync1_d  = {btn_dir, btn_start};
    sync2_d  = sync1_q;
    db_dly_d = db_q;
    pulse_d  = db_q & ~db_dly_q;
    db_d     = db_q;
    dcnt_d   = '0;
    // Any sample agreeing with the accepted level restarts the stability count.
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (dcnt_q[i] == DEB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    hcnt_d = '0;
    if (db_q[0]) begin
      hcnt_d = (hcnt_q == LONG_LAST) ? hcnt_q : hcnt_q + CNT_W'(1);
    end
    // Saturation at LONG_LAST means this matches only once per hold.
    long_hit = db_q[0] && (hcnt_q == LONG_PRE);
    active   = (state_q == ST_RUN) || (state_q == ST_PAUSE);

    state_d = state_q;
    dir_d   = dir_q;
    clear_d = 1'b0;
    case (state_q)
      ST_IDLE:  if (pulse_q[0]) state_d = ST_RUN;
      ST_RUN:   if (pulse_q[0]) state_d = ST_PAUSE;
      ST_PAUSE: if (pulse_q[0]) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
    if (pulse_q[1] && active) begin
      dir_d = ~dir_q;
    end
    if (long_hit && active) begin
      state_d = ST_IDLE;
      dir_d   = 1'b0;
      clear_d = 1'b1;
    end
    run_d    = (state_d == ST_RUN);
    paused_d = (state_d == ST_PAUSE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      pulse_q  <= '0;
      dcnt_q   <= '0;
      hcnt_q   <= '0;
      state_q  <= ST_IDLE;
      dir_q    <= 1'b0;
      clear_q  <= 1'b0;
      run_q    <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      pulse_q  <= pulse_d;
      dcnt_q   <= dcnt_d;
      hcnt_q   <= hcnt_d;
      state_q  <= state_d;
      dir_q    <= dir_d;
      clear_q  <= clear_d;
      run_q    <= run_d;
      paused_q <= paused_d;
    end
  end

  assign run         = run_q;
  assign paused      = paused_q;
  assign dir         = dir_q;
  assign clear       = clear_q;
  assign start_pulse = pulse_q[0];
  assign dir_pulse   = pulse_q[1];
  assign state       = state_q;

endmodule
